// File: rtl/irq_controller_pkg.sv
// Shared CPU definitions: exception vectors, interrupt source count and
// interrupt controller state encodings.
package irq_controller_pkg;

  localparam int unsigned NUM_IRQ   = 4;
  localparam int unsigned IRQ_IDX_W = 2;

  localparam logic [31:0] VECTOR_RESET    = 32'h0000_0000;
  localparam logic [31:0] VECTOR_SYSCALL  = 32'h0000_0004;
  localparam logic [31:0] VECTOR_IRQ_BASE = 32'h0000_0008;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_SERVICE  = 2'd2,
    ST_RETIRE   = 2'd3
  } irq_state_e;

  // Handler address for a hardware source: one word per source above the base.
  function automatic logic [31:0] irq_vector(input logic [IRQ_IDX_W-1:0] id);
    return VECTOR_IRQ_BASE + {{(32-IRQ_IDX_W-2){1'b0}}, id, 2'b00};
  endfunction

  function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [IRQ_IDX_W-1:0] id);
    return NUM_IRQ'(1) << id;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
  import irq_controller_pkg::*;
(
  input  logic [NUM_IRQ-1:0]   req_i,
  output logic                 valid_o,
  output logic [IRQ_IDX_W-1:0] idx_o
);

  // Scan from the highest index down so the lowest set bit is the last to land.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req_i[i-1]) begin
        valid_o = 1'b1;
        idx_o   = IRQ_IDX_W'(i-1);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Hardware interrupt controller: edge capture, mask, fixed-priority selection
// and a non-nesting dispatch/service/retire sequence.
module irq_controller
  import irq_controller_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_system,
  input  logic [NUM_IRQ-1:0]   irq_req,
  input  logic                 mask_we,
  input  logic [NUM_IRQ-1:0]   mask_wdata,
  input  logic                 do_syscall_it,
  input  logic                 do_it_return,
  input  logic                 seq_busy,
  output logic                 do_hw_it,
  output logic [31:0]          hw_vector,
  output logic [NUM_IRQ-1:0]   irq_ack,
  output logic [NUM_IRQ-1:0]   irq_pending,
  output logic [NUM_IRQ-1:0]   irq_mask,
  output logic                 in_service,
  output logic [IRQ_IDX_W-1:0] in_service_id
);

  irq_state_e             state_q;
  logic [NUM_IRQ-1:0]     req_q;
  logic [NUM_IRQ-1:0]     pending_q, pending_d;
  logic [NUM_IRQ-1:0]     mask_q;
  logic [NUM_IRQ-1:0]     rise;
  logic [NUM_IRQ-1:0]     clr;
  logic [NUM_IRQ-1:0]     ack_q;
  logic [31:0]            vector_q;
  logic                   do_hw_it_q;
  logic                   in_service_q;
  logic [IRQ_IDX_W-1:0]   id_q;
  logic                   cand_valid;
  logic [IRQ_IDX_W-1:0]   cand_idx;

  irq_prio_enc u_prio (
    .req_i   (pending_q & mask_q),
    .valid_o (cand_valid),
    .idx_o   (cand_idx)
  );

  // Pending update: clear of the dispatched source, then OR in new edges so a
  // fresh edge in the same cycle keeps the bit set.
  always_comb begin
    rise      = irq_req & ~req_q;
    clr       = '0;
    if (state_q == ST_DISPATCH && enable_system) begin
      clr = irq_onehot(id_q);
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  // Edge register and pending capture run independently of enable_system.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= irq_req;
      pending_q <= pending_d;
    end
  end

  // Mask register, frozen while the system is not enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '0;
    end else if (mask_we && enable_system) begin
      mask_q <= mask_wdata;
    end
  end

  // Dispatch sequencer; outputs are loaded on the transition into each state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      do_hw_it_q   <= 1'b0;
      vector_q     <= '0;
      ack_q        <= '0;
      in_service_q <= 1'b0;
    end else if (enable_system) begin
      case (state_q)
        ST_IDLE: begin
          if (cand_valid && !seq_busy && !do_syscall_it && !do_it_return) begin
            state_q      <= ST_DISPATCH;
            id_q         <= cand_idx;
            do_hw_it_q   <= 1'b1;
            vector_q     <= irq_vector(cand_idx);
            ack_q        <= irq_onehot(cand_idx);
            in_service_q <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          state_q    <= ST_SERVICE;
          do_hw_it_q <= 1'b0;
          vector_q   <= '0;
          ack_q      <= '0;
        end
        ST_SERVICE: begin
          if (do_it_return) begin
            state_q <= ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          if (!seq_busy) begin
            state_q      <= ST_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          do_hw_it_q   <= 1'b0;
          vector_q     <= '0;
          ack_q        <= '0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign do_hw_it      = do_hw_it_q;
  assign hw_vector     = vector_q;
  assign irq_ack       = ack_q;
  assign irq_pending   = pending_q;
  assign irq_mask      = mask_q;
  assign in_service    = in_service_q;
  assign in_service_id = id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller with a dispatch scoreboard.
module tb_irq_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_system;
  logic [3:0]  irq_req;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        do_syscall_it;
  logic        do_it_return;
  logic        seq_busy;
  logic        do_hw_it;
  logic [31:0] hw_vector;
  logic [3:0]  irq_ack;
  logic [3:0]  irq_pending;
  logic [3:0]  irq_mask;
  logic        in_service;
  logic [1:0]  in_service_id;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [31:0] vec;
    logic [3:0]  ack;
    logic [1:0]  id;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  irq_controller dut (
    .clock         (clock),
    .reset         (reset),
    .enable_system (enable_system),
    .irq_req       (irq_req),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .do_syscall_it (do_syscall_it),
    .do_it_return  (do_it_return),
    .seq_busy      (seq_busy),
    .do_hw_it      (do_hw_it),
    .hw_vector     (hw_vector),
    .irq_ack       (irq_ack),
    .irq_pending   (irq_pending),
    .irq_mask      (irq_mask),
    .in_service    (in_service),
    .in_service_id (in_service_id)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Dispatch monitor: pops the scoreboard on every do_hw_it, checks idle outputs otherwise.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (do_hw_it === 1'b1) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_dispatch vector=%h ack=%b required=no dispatch", hw_vector, irq_ack);
        end else begin
          e = sb.pop_front();
          if (hw_vector !== e.vec || irq_ack !== e.ack || in_service_id !== e.id || in_service !== 1'b1) begin
            failures++;
            $display("FAIL dispatch got vec=%h ack=%b id=%0d insvc=%b required vec=%h ack=%b id=%0d insvc=1",
                     hw_vector, irq_ack, in_service_id, in_service, e.vec, e.ack, e.id);
          end
        end
      end else if (hw_vector !== 32'h0 || irq_ack !== 4'h0 || do_hw_it !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs got dohw=%b vec=%h ack=%b required 0/0/0", do_hw_it, hw_vector, irq_ack);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_exp(input int id);
    exp_t x;
    x.vec = 32'h8 + 32'(id) * 4;
    x.ack = 4'b0001 << id;
    x.id  = 2'(id);
    sb.push_back(x);
  endtask

  // Steps until the scoreboard drains to target entries or the bound expires.
  task automatic wait_dispatch(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (sb.size() <= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  // Return from service and let the sequencer go idle; ends in IDLE.
  task automatic service_done();
    do_it_return = 1'b1;
    tick();
    do_it_return = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_system = 1'b1; irq_req = '0; mask_we = 1'b0; mask_wdata = '0;
    do_syscall_it = 1'b0; do_it_return = 1'b0; seq_busy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (do_hw_it !== 1'b0 || hw_vector !== 32'h0 || irq_ack !== 4'h0 || irq_pending !== 4'h0 ||
        irq_mask !== 4'h0 || in_service !== 1'b0 || in_service_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_state dohw=%b vec=%h ack=%b pend=%b mask=%b insvc=%b id=%0d required all 0",
               do_hw_it, hw_vector, irq_ack, irq_pending, irq_mask, in_service, in_service_id);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    write_mask(4'b1111);
    push_exp(2);
    irq_req = 4'b0100;
    tick();
    checks++;
    if (irq_pending !== 4'b0100) begin
      failures++; $display("FAIL single_pending got=%b required=0100", irq_pending);
    end
    wait_dispatch(0, 5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout queue=%0d required=0", sb.size()); end
    tick();
    checks++;
    if (irq_pending !== 4'b0000 || in_service !== 1'b1 || in_service_id !== 2'd2) begin
      failures++;
      $display("FAIL single_service pend=%b insvc=%b id=%0d required 0000/1/2", irq_pending, in_service, in_service_id);
    end
    service_done();
    checks++;
    if (in_service !== 1'b0) begin failures++; $display("FAIL single_retire insvc=%b required=0", in_service); end
    irq_req = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    bit ok;
    push_exp(1);
    push_exp(3);
    irq_req = 4'b1010;
    wait_dispatch(1, 6, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL prio_first_timeout queue=%0d required=1", sb.size()); end
    tick();
    checks++;
    if (irq_pending !== 4'b1000 || in_service_id !== 2'd1) begin
      failures++; $display("FAIL prio_pending pend=%b id=%0d required 1000/1", irq_pending, in_service_id);
    end
    seq_busy = 1'b1;
    service_done();
    tick();
    checks++;
    if (in_service !== 1'b1 || sb.size() != 1) begin
      failures++; $display("FAIL prio_retire_hold insvc=%b queue=%0d required 1/1", in_service, sb.size());
    end
    seq_busy = 1'b0;
    wait_dispatch(0, 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL prio_second_timeout queue=%0d required=0", sb.size()); end
    tick();
    service_done();
    irq_req = 4'b0000;
    tick();
  endtask

  task automatic test_masked();
    bit ok;
    write_mask(4'b0000);
    irq_req = 4'b0001;
    repeat (4) tick();
    checks++;
    if (irq_pending !== 4'b0001 || in_service !== 1'b0) begin
      failures++; $display("FAIL masked_pending pend=%b insvc=%b required 0001/0", irq_pending, in_service);
    end
    push_exp(0);
    write_mask(4'b0001);
    wait_dispatch(0, 3, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL unmask_timeout queue=%0d required=0", sb.size()); end
    tick();
    service_done();
  endtask

  task automatic test_syscall();
    bit ok;
    write_mask(4'b1111);
    do_syscall_it = 1'b1;
    irq_req = 4'b1000;
    repeat (3) tick();
    checks++;
    if (irq_pending !== 4'b1000 || in_service !== 1'b0) begin
      failures++; $display("FAIL syscall_block pend=%b insvc=%b required 1000/0", irq_pending, in_service);
    end
    do_syscall_it = 1'b0;
    seq_busy = 1'b1;
    repeat (3) tick();
    checks++;
    if (in_service !== 1'b0) begin failures++; $display("FAIL busy_block insvc=%b required=0", in_service); end
    push_exp(3);
    seq_busy = 1'b0;
    wait_dispatch(0, 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL syscall_release_timeout queue=%0d required=0", sb.size()); end
    tick();
    service_done();
  endtask

  task automatic test_enable_hold();
    bit ok;
    enable_system = 1'b0;
    irq_req = 4'b1001;
    write_mask(4'b0000);
    repeat (3) tick();
    checks++;
    if (irq_pending !== 4'b0001 || irq_mask !== 4'b1111 || in_service !== 1'b0) begin
      failures++;
      $display("FAIL enable_hold pend=%b mask=%b insvc=%b required 0001/1111/0", irq_pending, irq_mask, in_service);
    end
    push_exp(0);
    enable_system = 1'b1;
    wait_dispatch(0, 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL enable_resume_timeout queue=%0d required=0", sb.size()); end
    tick();
    service_done();
    irq_req = 4'b0000;
    tick();
  endtask

  task automatic test_same_cycle_edge();
    bit ok;
    push_exp(2);
    irq_req = 4'b0100;
    tick();
    irq_req = 4'b0000;
    wait_dispatch(0, 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL edge_first_timeout queue=%0d required=0", sb.size()); end
    irq_req = 4'b0100;
    tick();
    checks++;
    if (irq_pending !== 4'b0100 || in_service !== 1'b1) begin
      failures++; $display("FAIL edge_wins pend=%b insvc=%b required 0100/1", irq_pending, in_service);
    end
    push_exp(2);
    service_done();
    checks++;
    if (in_service !== 1'b0) begin failures++; $display("FAIL edge_retire insvc=%b required=0", in_service); end
    wait_dispatch(0, 3, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL edge_second_timeout queue=%0d required=0", sb.size()); end
    tick();
    service_done();
  endtask

  task automatic test_reset_mid_service();
    bit ok;
    push_exp(1);
    irq_req = 4'b0110;
    wait_dispatch(0, 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_dispatch_timeout queue=%0d required=0", sb.size()); end
    tick();
    reset   = 1'b1;
    irq_req = 4'b0000;
    tick();
    checks++;
    if (in_service !== 1'b0 || irq_pending !== 4'h0 || irq_mask !== 4'h0 || irq_ack !== 4'h0 || do_hw_it !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_service insvc=%b pend=%b mask=%b ack=%b dohw=%b required all 0",
               in_service, irq_pending, irq_mask, irq_ack, do_hw_it);
    end
    reset   = 1'b0;
    irq_req = 4'b1000;
    repeat (5) tick();
    checks++;
    if (irq_pending !== 4'b1000 || in_service !== 1'b0) begin
      failures++; $display("FAIL post_reset_masked pend=%b insvc=%b required 1000/0", irq_pending, in_service);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_syscall();
    test_enable_hold();
    test_same_cycle_edge();
    test_reset_mid_service();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover queue=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have port clock, input, 1, system clock; all flops update on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port enable_system, input, 1, FSM advance enable.
REQ-004 SHALL have port irq_req, input, 4, hardware interrupt sources, level in, rising-edge sensitive.
REQ-005 SHALL have port mask_we, input, 1, write strobe for mask register.
REQ-006 SHALL have port mask_wdata, input, 4, new mask value; 1 = source enabled.
REQ-007 SHALL have port do_syscall_it, input, 1, software syscall request seen by the context sequencer.
REQ-008 SHALL have port do_it_return, input, 1, return-from-interrupt request.
REQ-009 SHALL have port seq_busy, input, 1, context sequencer active (do_it_state).
REQ-010 SHALL have port do_hw_it, output, 1, one-cycle dispatch pulse to the context sequencer.
REQ-011 SHALL have port hw_vector, output, 32, handler address, valid while do_hw_it is high.
REQ-012 SHALL have port irq_ack, output, 4, one-hot one-cycle acknowledge to the dispatched source.
REQ-013 SHALL have port irq_pending, output, 4, pending register.
REQ-014 SHALL have port irq_mask, output, 4, mask register.
REQ-015 SHALL have port in_service, output, 1, a hardware interrupt is being serviced.
REQ-016 SHALL have port in_service_id, output, 2, index of the serviced source.

Function
REQ-017 SHALL register irq_req each cycle; a 0->1 transition sets irq_pending[n] on the next edge regardless of mask or enable_system.
REQ-018 SHALL, on mask_we, load irq_mask from mask_wdata on the next edge; masked sources stay pending but are never dispatched.
REQ-019 SHALL select as candidate the lowest index n with irq_pending[n] & irq_mask[n] (fixed priority, 0 highest).
REQ-020 SHALL implement FSM IDLE, DISPATCH, SERVICE, RETIRE; transitions occur only when enable_system=1.
REQ-021 IDLE->DISPATCH SHALL occur when a candidate exists, seq_busy=0, do_syscall_it=0 and do_it_return=0; the candidate id is latched into in_service_id.
REQ-022 In DISPATCH SHALL assert do_hw_it=1, hw_vector=32'h0000_0008+4*in_service_id, and irq_ack[in_service_id]=1 for exactly one cycle, clear that pending bit, and move to SERVICE.
REQ-023 SHALL hold in_service=1 in DISPATCH, SERVICE and RETIRE; 0 in IDLE.
REQ-024 SERVICE->RETIRE SHALL occur on do_it_return=1; no nesting: further candidates wait.
REQ-025 RETIRE->IDLE SHALL occur on the first cycle seq_busy=0 after entering RETIRE.
REQ-026 A syscall SHALL take precedence: do_syscall_it in IDLE blocks dispatch for that cycle; syscall in SERVICE is ignored by this block.
REQ-027 A new rising edge on the source being cleared in the same cycle SHALL win: pending bit ends set.
REQ-028 do_hw_it, irq_ack SHALL be 0 in every state other than DISPATCH; hw_vector SHALL be 0 outside DISPATCH.
REQ-029 With enable_system=0, FSM, in_service_id and mask SHALL hold; pending capture continues.

Reset
REQ-030 On reset, state=IDLE, irq_pending=0, irq_mask=0, in_service_id=0, edge register=0; all outputs 0 on the following cycle.
REQ-031 Reset mid-service SHALL abandon the service with no ack or vector emitted.

Structure
REQ-032 Vector constants (VECTOR_RESET 0x0, VECTOR_SYSCALL 0x4, VECTOR_IRQ_BASE 0x8), state encodings and source count SHALL reside in the shared CPU definitions package.
REQ-033 The fixed-priority encoder SHALL be a sub-module named irq_prio_enc (4-bit request in, valid plus 2-bit index out).

Verification
REQ-034 Mask=4'b1111, edge on irq_req[2] -> pending=4'b0100, do_hw_it pulse with hw_vector=0x10, irq_ack=4'b0100, pending cleared.
REQ-035 Simultaneous edges on irq_req[1] and [3] -> source 1 dispatched (vector 0x0C); after do_it_return and seq_busy low, source 3 dispatched (vector 0x14).
REQ-036 Mask=4'b0000, edge on irq_req[0] -> no dispatch, pending=4'b0001; write mask=4'b0001 -> dispatch vector 0x08 within 3 cycles.
REQ-037 Candidate present with do_syscall_it=1 and then seq_busy=1 -> no do_hw_it until seq_busy returns 0.
REQ-038 Reset asserted in SERVICE -> in_service=0, pending=0, mask=0, no ack; subsequent edge with mask unwritten -> no dispatch.
